// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports (B wins on
// collision), same-cycle write bypass, optional hardwired zero register and a sequential clear engine.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wa_en,
    input  logic [ADDR_W-1:0]          wa_addr,
    input  logic [DATA_W-1:0]          wa_din,
    input  logic                       wb_en,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_din,
    input  logic                       clr_req,
    output logic                       clr_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              idle;
    logic              wa_commit, wb_commit;

    assign idle     = (state_q == IDLE);
    assign clr_busy = (state_q == CLEAR);

    // Only writes that actually land in the array are committed and therefore bypassed.
    assign wa_commit = idle && wa_en && !((ZERO_REG != 0) && (wa_addr == '0));
    assign wb_commit = idle && wb_en && !((ZERO_REG != 0) && (wb_addr == '0));

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            if (!idle) begin
                mem_q[clr_cnt_q] <= '0;
            end
            // Port B is applied last so it wins a same-address collision.
            if (wa_commit) begin
                mem_q[wa_addr] <= wa_din;
            end
            if (wb_commit) begin
                mem_q[wb_addr] <= wb_din;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdat;

        assign ra = rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rdat = '0;
            end else if (wb_commit && (wb_addr == ra)) begin
                rdat = wb_din;
            end else if (wa_commit && (wa_addr == ra)) begin
                rdat = wa_din;
            end else begin
                rdat = mem_q[ra];
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = rdat;
    end

endmodule
